// File: rtl/serdesphy_status_irq_if.sv
// Byte-wide CSR bus shared by the SerDes PHY register blocks.
// The I2C slave is the master; each register window is a slave.
interface serdesphy_status_irq_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_write_en;
  logic       reg_read_en;
  logic [7:0] reg_rdata;
  logic       reg_hit;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_write_en,
    output reg_read_en,
    input  reg_rdata,
    input  reg_hit
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_write_en,
    input  reg_read_en,
    output reg_rdata,
    output reg_hit
  );
endinterface

// File: rtl/serdesphy_status_irq.sv
// Status/event aggregator: synchronised raw levels, W1C sticky bits,
// per-source mask, level + pulse interrupt, one saturating edge counter.
module serdesphy_status_irq #(
  parameter int unsigned NUM_SRC     = 16,
  parameter int unsigned CNT_W       = 8,
  parameter logic [7:0]  BASE_ADDR   = 8'h40,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] evt_in,
  serdesphy_status_irq_if.slave bus,
  output logic               irq,
  output logic               irq_pulse
);

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] evt;
  logic [NUM_SRC-1:0] dly_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] cap;

  logic [NUM_SRC-1:0] sticky_q, sticky_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic               irq_en_q, irq_en_d;
  logic               edge_q, edge_d;
  logic [4:0]         sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         shadow_q, shadow_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               irq_q, irq_d;
  logic               pulse_q, pulse_d;

  logic [3:0]         off;
  logic [1:0]         lane;
  logic               hit, rd, wr;
  logic               wr_stk, wr_msk, wr_ctl, wr_sel;
  logic [NUM_SRC-1:0] wsrc, ben;
  logic [31:0]        raw32, stk32, msk32, rise32;
  logic [15:0]        cnt16;
  logic               sel_ok, cnt_clr;

  function automatic logic [7:0] bsel(
    input logic [31:0] v,
    input logic [1:0]  b
  );
    logic [7:0] r;
    unique case (b)
      2'd0: r = v[7:0];
      2'd1: r = v[15:8];
      2'd2: r = v[23:16];
      default: r = v[31:24];
    endcase
    return r;
  endfunction

  assign evt  = sync_q[SYNC_STAGES-1];
  assign rise = evt & ~dly_q;
  assign cap  = edge_q ? rise : evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      dly_q <= '0;
    end else begin
      sync_q[0] <= evt_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      dly_q <= evt;
    end
  end

  assign off  = bus.reg_addr[3:0];
  assign lane = off[1:0];
  assign hit  = (bus.reg_addr[7:4] == BASE_ADDR[7:4]);
  assign rd   = bus.reg_read_en & hit;
  assign wr   = bus.reg_write_en & hit;

  assign wr_stk = wr && (off[3:2] == 2'd1);
  assign wr_msk = wr && (off[3:2] == 2'd2);
  assign wr_ctl = wr && (off == 4'hC);
  assign wr_sel = wr && (off == 4'hD);

  // Per-source view of the write byte and its lane enable.
  always_comb begin
    wsrc = '0;
    ben  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      wsrc[i] = bus.reg_wdata[3'(i % 8)];
      ben[i]  = (lane == 2'(i / 8));
    end
  end

  assign raw32  = 32'(evt);
  assign stk32  = 32'(sticky_q);
  assign msk32  = 32'(mask_q);
  assign rise32 = 32'(rise);
  assign cnt16  = 16'(cnt_q);
  assign sel_ok = ({1'b0, sel_q} < 6'(NUM_SRC));

  assign cnt_clr = (wr_ctl & bus.reg_wdata[2]) | wr_sel | ~sel_ok;

  always_comb begin
    sticky_d = sticky_q;
    mask_d   = mask_q;
    irq_en_d = irq_en_q;
    edge_d   = edge_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    // Capture is ORed in last so a new event beats a W1C.
    if (wr_stk) begin
      sticky_d = sticky_q & ~(wsrc & ben);
    end
    sticky_d = sticky_d | cap;
    if (wr_msk) begin
      mask_d = (mask_q & ~ben) | (wsrc & ben);
    end
    if (wr_ctl) begin
      irq_en_d = bus.reg_wdata[0];
      edge_d   = bus.reg_wdata[1];
    end
    if (wr_sel) begin
      sel_d = bus.reg_wdata[4:0];
    end
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (rise32[sel_q] && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign irq_d   = irq_en_q & |(sticky_q & ~mask_q);
  assign pulse_d = irq_d & ~irq_q;

  // Reads sample pre-write state, so a same-cycle write is not visible.
  always_comb begin
    rdata_d  = rdata_q;
    shadow_d = shadow_q;
    if (rd) begin
      unique case (1'b1)
        (off[3:2] == 2'd0): rdata_d = bsel(raw32, lane);
        (off[3:2] == 2'd1): rdata_d = bsel(stk32, lane);
        (off[3:2] == 2'd2): rdata_d = bsel(msk32, lane);
        (off == 4'hC): rdata_d = {6'b0, edge_q, irq_en_q};
        (off == 4'hD): rdata_d = {3'b0, sel_q};
        (off == 4'hE): begin
          rdata_d  = cnt16[7:0];
          shadow_d = cnt16[15:8];
        end
        default: rdata_d = shadow_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
      mask_q   <= '1;
      irq_en_q <= 1'b0;
      edge_q   <= 1'b0;
      sel_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      mask_q   <= mask_d;
      irq_en_q <= irq_en_d;
      edge_q   <= edge_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
      pulse_q  <= pulse_d;
    end
  end

  assign bus.reg_hit   = hit;
  assign bus.reg_rdata = rdata_q;
  assign irq           = irq_q;
  assign irq_pulse     = pulse_q;

endmodule
